// File: rtl/graphics_type.sv
// Shared graphics types: vertices, triangles, colors.
// Also holds table-size constants and fetcher state encoding.
package graphics_type;

    localparam int MAX_VERTICES  = 18;
    localparam int MAX_TRIANGLES = 24;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vertex_3d_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef struct packed {
        logic [4:0] v0;
        logic [4:0] v1;
        logic [4:0] v2;
        color_t     color;
    } triangle_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/triangle_fetcher_lookup.sv
// Vertex index resolver: out-of-range indices give the
// origin and raise err so the frame can keep going.
import graphics_type::*;

module tri_vertex_lookup #(
    parameter int MAX_VERTS = 18
) (
    input  vertex_3d_t vertices [0:MAX_VERTS-1],
    input  logic [4:0] index,
    output vertex_3d_t vertex,
    output logic       err
);

    // Range-checked table read
    always_comb begin
        vertex = '0;
        err    = 1'b0;
        if (int'(index) < MAX_VERTS) begin
            vertex = vertices[index];
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/triangle_fetcher.sv
// Walks the triangle list once per start and presents each
// triangle with resolved corners over a valid/ready port.
import graphics_type::*;

module triangle_fetcher #(
    parameter int MAX_VERTS = 18,
    parameter int MAX_TRIS  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  vertex_3d_t vertices [0:MAX_VERTS-1],
    input  triangle_t  triangles [0:MAX_TRIS-1],
    input  logic [4:0] num_triangles,
    output logic       tri_valid,
    input  logic       tri_ready,
    output vertex_3d_t p0,
    output vertex_3d_t p1,
    output vertex_3d_t p2,
    output color_t     tri_color,
    output logic [4:0] tri_index,
    output logic       busy,
    output logic       done,
    output logic       idx_err
);

    localparam logic [4:0] TRIS_CAP = 5'(MAX_TRIS);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [4:0] idx;
    logic [4:0] count;
    logic [4:0] load_idx;
    logic       hs;
    logic       last;
    logic       load;
    triangle_t  cur_tri;
    vertex_3d_t lk0, lk1, lk2;
    logic       err0, err1, err2;

    assign hs       = tri_valid & tri_ready;
    assign last     = ({1'b0, idx} + 6'd1) >= {1'b0, count};
    assign load_idx = (state_q == PRESENT) ? idx + 5'd1 : idx;
    assign load     = ((state_q == FETCH) && (count != 5'd0))
                    || ((state_q == PRESENT) && hs && !last);

    // Live read of the triangle about to be loaded
    always_comb begin
        cur_tri = '0;
        if (int'(load_idx) < MAX_TRIS) begin
            cur_tri = triangles[load_idx];
        end
    end

    tri_vertex_lookup #(.MAX_VERTS(MAX_VERTS)) u_lk0 (
        .vertices (vertices),
        .index    (cur_tri.v0),
        .vertex   (lk0),
        .err      (err0)
    );

    tri_vertex_lookup #(.MAX_VERTS(MAX_VERTS)) u_lk1 (
        .vertices (vertices),
        .index    (cur_tri.v1),
        .vertex   (lk1),
        .err      (err1)
    );

    tri_vertex_lookup #(.MAX_VERTS(MAX_VERTS)) u_lk2 (
        .vertices (vertices),
        .index    (cur_tri.v2),
        .vertex   (lk2),
        .err      (err2)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = (count == 5'd0) ? DONE : PRESENT;
            PRESENT: if (hs && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs follow the state
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Frame counters, presented triangle and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            count     <= '0;
            tri_valid <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            tri_color <= '0;
            tri_index <= '0;
            idx_err   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                count   <= (num_triangles > TRIS_CAP)
                         ? TRIS_CAP : num_triangles;
                idx     <= '0;
                idx_err <= 1'b0;
            end
            if (load) begin
                idx       <= load_idx;
                p0        <= lk0;
                p1        <= lk1;
                p2        <= lk2;
                tri_color <= cur_tri.color;
                tri_index <= load_idx;
                tri_valid <= 1'b1;
                if (err0 | err1 | err2) idx_err <= 1'b1;
            end else if ((state_q == PRESENT) && hs) begin
                tri_valid <= 1'b0;
            end
        end
    end

endmodule
